// File: rtl/dsp_macc_seq_pkg.sv
// Shared widths and FSM state encoding for the DSP38 multiply-accumulate feeder.
package dsp_macc_seq_pkg;

    localparam int A_W     = 20;
    localparam int B_W     = 18;
    localparam int Z_W     = 38;
    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_macc_sequencer.sv
// Frames (a,b) operand beats into a DSP38 MACC slice and returns one dot product per frame.
// Optional DSP_MACC_SEQ_TERMS_EN adds the m_terms output carrying the frame's beat count.
module dsp_macc_sequencer
    import dsp_macc_seq_pkg::*;
#(
    parameter int MAC_LAT   = 2,
    parameter int MAX_TERMS = 256
) (
    input  logic               clk,
    input  logic               lreset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [A_W-1:0]     s_a,
    input  logic [B_W-1:0]     s_b,
    input  logic               s_last,
    input  logic               cfg_unsigned_a,
    input  logic               cfg_unsigned_b,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_round,
    input  logic               cfg_saturate,
    input  logic               cfg_subtract,
    output logic [A_W-1:0]     dsp_a,
    output logic [B_W-1:0]     dsp_b,
    output logic               dsp_load_acc,
    output logic [2:0]         dsp_feedback,
    output logic               dsp_unsigned_a,
    output logic               dsp_unsigned_b,
    output logic [SHIFT_W-1:0] dsp_shift_right,
    output logic               dsp_round,
    output logic               dsp_saturate,
    output logic               dsp_subtract,
    input  logic [Z_W-1:0]     dsp_z,
`ifdef DSP_MACC_SEQ_TERMS_EN
    output logic [$clog2(MAX_TERMS+1)-1:0] m_terms,
`endif
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Z_W-1:0]     m_z,
    output logic               m_trunc
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam int LAT_W = $clog2(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(MAC_LAT);

    state_t               state_q, state_d;
    logic                 s_ready_q, s_ready_d;
    logic [A_W-1:0]       dsp_a_q, dsp_a_d;
    logic [B_W-1:0]       dsp_b_q, dsp_b_d;
    logic                 load_q, load_d;
    logic                 ua_q, ua_d;
    logic                 ub_q, ub_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic                 round_q, round_d;
    logic                 sat_q, sat_d;
    logic                 sub_q, sub_d;
    logic [CNT_W-1:0]     term_cnt_q, term_cnt_d;
    logic [LAT_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic                 trunc_q, trunc_d;
    logic                 m_valid_q, m_valid_d;
    logic [Z_W-1:0]       m_z_q, m_z_d;
    logic                 m_trunc_q, m_trunc_d;
    logic                 hs;
    logic [CNT_W-1:0]     next_cnt;
`ifdef DSP_MACC_SEQ_TERMS_EN
    logic [CNT_W-1:0]     m_terms_q, m_terms_d;
`endif

    assign hs       = s_valid && s_ready_q;
    assign next_cnt = term_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        dsp_a_d     = '0;
        dsp_b_d     = '0;
        load_d      = 1'b0;
        ua_d        = ua_q;
        ub_d        = ub_q;
        shift_d     = shift_q;
        round_d     = round_q;
        sat_d       = sat_q;
        sub_d       = sub_q;
        term_cnt_d  = term_cnt_q;
        drain_cnt_d = drain_cnt_q;
        trunc_d     = trunc_q;
        m_valid_d   = m_valid_q;
        m_z_d       = m_z_q;
        m_trunc_d   = m_trunc_q;
`ifdef DSP_MACC_SEQ_TERMS_EN
        m_terms_d   = m_terms_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    ua_d        = cfg_unsigned_a;
                    ub_d        = cfg_unsigned_b;
                    shift_d     = cfg_shift;
                    round_d     = cfg_round;
                    sat_d       = cfg_saturate;
                    sub_d       = cfg_subtract;
                    dsp_a_d     = s_a;
                    dsp_b_d     = s_b;
                    load_d      = 1'b1;
                    term_cnt_d  = CNT_W'(1);
                    drain_cnt_d = '0;
                    trunc_d     = 1'b0;
                    if (s_last || (MAX_TERMS == 1)) begin
                        state_d = DRAIN;
                        trunc_d = !s_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // Idle cycles present zero operands so the accumulator holds its value.
                if (hs) begin
                    dsp_a_d    = s_a;
                    dsp_b_d    = s_b;
                    term_cnt_d = next_cnt;
                    if (s_last || (next_cnt == MAX_CNT)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                        trunc_d     = !s_last;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAT_CNT) begin
                    m_z_d     = dsp_z;
                    m_trunc_d = trunc_q;
                    m_valid_d = 1'b1;
`ifdef DSP_MACC_SEQ_TERMS_EN
                    m_terms_d = term_cnt_q;
`endif
                    state_d   = HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q + LAT_W'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            load_q      <= 1'b0;
            ua_q        <= 1'b0;
            ub_q        <= 1'b0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            sub_q       <= 1'b0;
            term_cnt_q  <= '0;
            drain_cnt_q <= '0;
            trunc_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_z_q       <= '0;
            m_trunc_q   <= 1'b0;
`ifdef DSP_MACC_SEQ_TERMS_EN
            m_terms_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
            load_q      <= load_d;
            ua_q        <= ua_d;
            ub_q        <= ub_d;
            shift_q     <= shift_d;
            round_q     <= round_d;
            sat_q       <= sat_d;
            sub_q       <= sub_d;
            term_cnt_q  <= term_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            trunc_q     <= trunc_d;
            m_valid_q   <= m_valid_d;
            m_z_q       <= m_z_d;
            m_trunc_q   <= m_trunc_d;
`ifdef DSP_MACC_SEQ_TERMS_EN
            m_terms_q   <= m_terms_d;
`endif
        end
    end

    assign s_ready         = s_ready_q;
    assign dsp_a           = dsp_a_q;
    assign dsp_b           = dsp_b_q;
    assign dsp_load_acc    = load_q;
    assign dsp_feedback    = 3'b000;
    assign dsp_unsigned_a  = ua_q;
    assign dsp_unsigned_b  = ub_q;
    assign dsp_shift_right = shift_q;
    assign dsp_round       = round_q;
    assign dsp_saturate    = sat_q;
    assign dsp_subtract    = sub_q;
    assign m_valid         = m_valid_q;
    assign m_z             = m_z_q;
    assign m_trunc         = m_trunc_q;
`ifdef DSP_MACC_SEQ_TERMS_EN
    assign m_terms         = m_terms_q;
`endif

endmodule

// File: tb/tb_dsp_macc_sequencer.sv
// Directed bench for dsp_macc_sequencer with a behavioural DSP38 MACC model (registered inputs,
// combinational accumulator output, two cycles of latency).
module tb_dsp_macc_sequencer;
    import dsp_macc_seq_pkg::*;

    localparam int MAC_LAT   = 2;
    localparam int MAX_TERMS = 8;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic               clk = 1'b0;
    logic               lreset;
    logic               s_valid;
    logic               s_ready;
    logic [A_W-1:0]     s_a;
    logic [B_W-1:0]     s_b;
    logic               s_last;
    logic               cfg_unsigned_a, cfg_unsigned_b;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               cfg_round, cfg_saturate, cfg_subtract;
    logic [A_W-1:0]     dsp_a;
    logic [B_W-1:0]     dsp_b;
    logic               dsp_load_acc;
    logic [2:0]         dsp_feedback;
    logic               dsp_unsigned_a, dsp_unsigned_b;
    logic [SHIFT_W-1:0] dsp_shift_right;
    logic               dsp_round, dsp_saturate, dsp_subtract;
    logic [Z_W-1:0]     dsp_z;
    logic               m_valid;
    logic               m_ready;
    logic [Z_W-1:0]     m_z;
    logic               m_trunc;
`ifdef DSP_MACC_SEQ_TERMS_EN
    logic [CNT_W-1:0]   m_terms;
`endif

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dsp_macc_sequencer #(.MAC_LAT(MAC_LAT), .MAX_TERMS(MAX_TERMS)) dut (
        .clk             (clk),
        .lreset          (lreset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_a             (s_a),
        .s_b             (s_b),
        .s_last          (s_last),
        .cfg_unsigned_a  (cfg_unsigned_a),
        .cfg_unsigned_b  (cfg_unsigned_b),
        .cfg_shift       (cfg_shift),
        .cfg_round       (cfg_round),
        .cfg_saturate    (cfg_saturate),
        .cfg_subtract    (cfg_subtract),
        .dsp_a           (dsp_a),
        .dsp_b           (dsp_b),
        .dsp_load_acc    (dsp_load_acc),
        .dsp_feedback    (dsp_feedback),
        .dsp_unsigned_a  (dsp_unsigned_a),
        .dsp_unsigned_b  (dsp_unsigned_b),
        .dsp_shift_right (dsp_shift_right),
        .dsp_round       (dsp_round),
        .dsp_saturate    (dsp_saturate),
        .dsp_subtract    (dsp_subtract),
        .dsp_z           (dsp_z),
`ifdef DSP_MACC_SEQ_TERMS_EN
        .m_terms         (m_terms),
`endif
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_z             (m_z),
        .m_trunc         (m_trunc)
    );

    // DSP model: input register stage, then accumulate; dsp_z is the accumulator itself.
    logic [A_W-1:0]      ra = '0;
    logic [B_W-1:0]      rb = '0;
    logic                rld = 1'b0, rsub = 1'b0, rua = 1'b0, rub = 1'b0;
    logic [Z_W-1:0]      acc = '0;
    logic signed [20:0]  ax;
    logic signed [18:0]  bx;
    logic signed [39:0]  prod;

    always_comb begin
        ax   = rua ? $signed({1'b0, ra}) : $signed({ra[A_W-1], ra});
        bx   = rub ? $signed({1'b0, rb}) : $signed({rb[B_W-1], rb});
        prod = ax * bx;
    end

    always @(posedge clk) begin
        ra   <= dsp_a;
        rb   <= dsp_b;
        rld  <= dsp_load_acc;
        rsub <= dsp_subtract;
        rua  <= dsp_unsigned_a;
        rub  <= dsp_unsigned_b;
        acc  <= (rld ? '0 : acc) + (rsub ? -prod[Z_W-1:0] : prod[Z_W-1:0]);
    end

    assign dsp_z = acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and returns #1 after the edge on which it was accepted.
    task automatic beat(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
        int n = 0;
        s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("beat_accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic ack();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("ack_m_valid_low", 64'(m_valid), 64'd0);
        check("ack_s_ready_high", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic quiet;
        lreset = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
        cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0; cfg_shift = '0;
        cfg_round = 1'b0; cfg_saturate = 1'b0; cfg_subtract = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_z", 64'(m_z), 64'd0);
        check("rst_m_trunc", 64'(m_trunc), 64'd0);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_dsp_load", 64'(dsp_load_acc), 64'd0);
        check("rst_dsp_fb", 64'(dsp_feedback), 64'd0);
        lreset = 1'b1;
        @(posedge clk); #1;
        check("idle_s_ready", 64'(s_ready), 64'd1);

        // Frame 1: back-to-back beats, cfg_subtract flipped mid-frame must be ignored.
        beat(20'd3, 18'd5, 1'b0);
        check("f1_dsp_a", 64'(dsp_a), 64'd3);
        check("f1_load_first", 64'(dsp_load_acc), 64'd1);
        cfg_subtract = 1'b1;
        beat(20'd2, 18'd7, 1'b0);
        check("f1_load_second", 64'(dsp_load_acc), 64'd0);
        check("f1_sub_held", 64'(dsp_subtract), 64'd0);
        beat(20'hFFFFF, 18'd4, 1'b0);
        beat(20'd10, 18'd10, 1'b1);
        wait_result(lat);
        check("f1_latency", 64'(lat), 64'(MAC_LAT + 1));
        check("f1_m_z", 64'(m_z), 64'd125);
        check("f1_trunc", 64'(m_trunc), 64'd0);
`ifdef DSP_MACC_SEQ_TERMS_EN
        check("f1_terms", 64'(m_terms), 64'd4);
`endif
        check("f1_hold_s_ready", 64'(s_ready), 64'd0);
        ack();
        cfg_subtract = 1'b0;

        // Frame 2: same terms with two idle cycles between beats.
        beat(20'd3, 18'd5, 1'b0);
        @(posedge clk); #1;
        check("f2_bubble_a", 64'(dsp_a), 64'd0);
        check("f2_bubble_load", 64'(dsp_load_acc), 64'd0);
        @(posedge clk); #1;
        beat(20'd2, 18'd7, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        beat(20'hFFFFF, 18'd4, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        beat(20'd10, 18'd10, 1'b1);
        wait_result(lat);
        check("f2_latency", 64'(lat), 64'(MAC_LAT + 1));
        check("f2_m_z", 64'(m_z), 64'd125);
        ack();

        // Frame 3: single subtracted term, then result held for 10 cycles with a beat waiting.
        cfg_subtract = 1'b1;
        beat(20'd6, 18'd7, 1'b1);
        check("f3_load", 64'(dsp_load_acc), 64'd1);
        check("f3_sub", 64'(dsp_subtract), 64'd1);
        cfg_subtract = 1'b0;
        wait_result(lat);
        check("f3_latency", 64'(lat), 64'(MAC_LAT + 1));
        check("f3_m_z", 64'(m_z), 64'h3F_FFFF_FFD6);
`ifdef DSP_MACC_SEQ_TERMS_EN
        check("f3_terms", 64'(m_terms), 64'd1);
`endif
        s_a = 20'd9; s_b = 18'd9; s_last = 1'b1; s_valid = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_z !== 38'h3F_FFFF_FFD6 || s_ready !== 1'b0 || m_valid !== 1'b1 ||
                dsp_load_acc !== 1'b0 || dsp_a !== '0)
                quiet = 1'b0;
        end
        check("f3_hold_stable", 64'(quiet), 64'd1);
        s_valid = 1'b0; s_last = 1'b0;
        ack();

        // Frame 4: MAX_TERMS beats without s_last truncate; the next beat opens a new frame.
        for (int i = 0; i < MAX_TERMS; i++) beat(20'd1, 18'd1, 1'b0);
        wait_result(lat);
        check("f4_latency", 64'(lat), 64'(MAC_LAT + 1));
        check("f4_m_z", 64'(m_z), 64'd8);
        check("f4_trunc", 64'(m_trunc), 64'd1);
`ifdef DSP_MACC_SEQ_TERMS_EN
        check("f4_terms", 64'(m_terms), 64'd8);
`endif
        ack();
        beat(20'd1, 18'd1, 1'b1);
        check("f5_new_frame_load", 64'(dsp_load_acc), 64'd1);
        wait_result(lat);
        check("f5_m_z", 64'(m_z), 64'd1);
        check("f5_trunc", 64'(m_trunc), 64'd0);
        ack();

        // Frame 6: reset during drain aborts the frame.
        beat(20'd3, 18'd5, 1'b1);
        @(posedge clk); #1;
        lreset = 1'b0;
        #2;
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_m_valid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        lreset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0) quiet = 1'b0;
        end
        check("abort_no_result", 64'(quiet), 64'd1);
        beat(20'd2, 18'd3, 1'b1);
        wait_result(lat);
        check("f7_latency", 64'(lat), 64'(MAC_LAT + 1));
        check("f7_m_z", 64'(m_z), 64'd6);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
